// File: rtl/branch_rs.sv
// Branch reservation station: holds dispatched branch/jump ops until both operands
// are ready, then presents the oldest ready one to the branch unit.
package branch_rs_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm_val;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic [4:0]  ROB_tag;
    logic        branch;
    logic        jump;
    logic        took_branch;
  } branch_entry_t;
endpackage

module branch_rs #(
  parameter type BE    = branch_rs_pkg::branch_entry_t,
  parameter int  DEPTH = 4,
  parameter int  TAG_W = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  BE                          disp_data_i,
  input  logic                       rs1_rdy_i,
  input  logic                       rs2_rdy_i,
  input  logic [TAG_W-1:0]           rs1_tag_i,
  input  logic [TAG_W-1:0]           rs2_tag_i,
  input  logic                       cdb_valid_i,
  input  logic [TAG_W-1:0]           cdb_tag_i,
  input  logic [31:0]                cdb_val_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output BE                          issue_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rs1_rdy_q;
  logic [DEPTH-1:0] rs2_rdy_q;
  logic [TAG_W-1:0] rs1_tag_q [DEPTH];
  logic [TAG_W-1:0] rs2_tag_q [DEPTH];
  logic [CNT_W-1:0] age_q     [DEPTH];
  BE                data_q    [DEPTH];
  logic [CNT_W-1:0] count_q;

  logic [DEPTH-1:0] wake1;
  logic [DEPTH-1:0] wake2;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] disp_we;
  logic [DEPTH-1:0] issue_clr;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] sel_age;
  logic [CNT_W-1:0] new_age;

  logic disp_fire;
  logic issue_fire;
  logic byp1;
  logic byp2;
  logic rs2_eff_rdy;
  logic disp_rs1_rdy;
  logic disp_rs2_rdy;
  BE    disp_entry;

  assign disp_ready_o  = !reset_i && !flush_i && (count_q < CNT_W'(DEPTH));
  assign issue_valid_o = !reset_i && !flush_i && sel_found;
  assign issue_data_o  = issue_valid_o ? data_q[sel_idx] : '0;
  assign count_o       = count_q;

  assign disp_fire  = disp_valid_i && disp_ready_o;
  assign issue_fire = issue_valid_o && issue_ready_i;
  // Slots ahead of the issued one shift down, so a same-cycle dispatch lands after them.
  assign new_age    = count_q - CNT_W'(issue_fire);

  // Jumps carry no second source; a not-ready operand may also be caught off the CDB on dispatch.
  assign rs2_eff_rdy  = rs2_rdy_i || disp_data_i.jump;
  assign byp1         = cdb_valid_i && !rs1_rdy_i && (rs1_tag_i == cdb_tag_i);
  assign byp2         = cdb_valid_i && !rs2_eff_rdy && (rs2_tag_i == cdb_tag_i);
  assign disp_rs1_rdy = rs1_rdy_i || byp1;
  assign disp_rs2_rdy = rs2_eff_rdy || byp2;

  always_comb begin
    disp_entry = disp_data_i;
    if (byp1) disp_entry.rs1_val = cdb_val_i;
    if (byp2) disp_entry.rs2_val = cdb_val_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign wake1[gi]     = !flush_i && cdb_valid_i && valid_q[gi] && !rs1_rdy_q[gi]
                             && (rs1_tag_q[gi] == cdb_tag_i);
      assign wake2[gi]     = !flush_i && cdb_valid_i && valid_q[gi] && !rs2_rdy_q[gi]
                             && (rs2_tag_q[gi] == cdb_tag_i);
      assign ready_vec[gi] = valid_q[gi] && rs1_rdy_q[gi] && rs2_rdy_q[gi];
      assign disp_we[gi]   = disp_fire && (free_idx == IDX_W'(gi));
      assign issue_clr[gi] = issue_fire && (sel_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Oldest ready entry wins: smallest age rank among ready slots.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_vec[i] && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i]     <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_we[i]) begin
          valid_q[i]   <= 1'b1;
          rs1_rdy_q[i] <= disp_rs1_rdy;
          rs2_rdy_q[i] <= disp_rs2_rdy;
          rs1_tag_q[i] <= rs1_tag_i;
          rs2_tag_q[i] <= rs2_tag_i;
          age_q[i]     <= new_age;
        end else if (issue_clr[i]) begin
          valid_q[i]   <= 1'b0;
          rs1_rdy_q[i] <= 1'b0;
          rs2_rdy_q[i] <= 1'b0;
        end else begin
          if (issue_fire && valid_q[i] && (age_q[i] > sel_age)) age_q[i] <= age_q[i] - 1'b1;
          if (wake1[i]) rs1_rdy_q[i] <= 1'b1;
          if (wake2[i]) rs2_rdy_q[i] <= 1'b1;
        end
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid slot.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_we[i]) begin
        data_q[i] <= disp_entry;
      end else begin
        if (wake1[i]) data_q[i].rs1_val <= cdb_val_i;
        if (wake2[i]) data_q[i].rs2_val <= cdb_val_i;
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: dispatch, wakeup, bypass, ordering, full, flush, reset.
module tb_branch_rs;
  typedef branch_rs_pkg::branch_entry_t be_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        disp_valid_i = 1'b0;
  logic        disp_ready_o;
  be_t         disp_data_i = '0;
  logic        rs1_rdy_i = 1'b0;
  logic        rs2_rdy_i = 1'b0;
  logic [4:0]  rs1_tag_i = '0;
  logic [4:0]  rs2_tag_i = '0;
  logic        cdb_valid_i = 1'b0;
  logic [4:0]  cdb_tag_i = '0;
  logic [31:0] cdb_val_i = '0;
  logic        issue_valid_o;
  logic        issue_ready_i = 1'b0;
  be_t         issue_data_o;
  logic [2:0]  count_o;

  int tests = 0;
  int fails = 0;

  branch_rs #(.BE(be_t), .DEPTH(4), .TAG_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_data_i(disp_data_i),
    .rs1_rdy_i(rs1_rdy_i), .rs2_rdy_i(rs2_rdy_i), .rs1_tag_i(rs1_tag_i), .rs2_tag_i(rs2_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_data_o(issue_data_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock, then drop single-cycle inputs.
  task automatic step();
    @(posedge clk_i);
    #1;
    disp_valid_i = 1'b0;
    cdb_valid_i  = 1'b0;
    flush_i      = 1'b0;
    #1;
  endtask

  task automatic disp(input logic [31:0] pc, input logic r1, input logic [4:0] t1,
                      input logic [31:0] v1, input logic r2, input logic [4:0] t2,
                      input logic [31:0] v2, input logic jmp);
    be_t e;
    e = '0;
    e.pc = pc;
    e.imm_val = 32'h10;
    e.rs1_val = v1;
    e.rs2_val = v2;
    e.rd_addr = 5'd1;
    e.ROB_tag = pc[6:2];
    e.branch = !jmp;
    e.jump = jmp;
    disp_data_i  = e;
    rs1_rdy_i    = r1;
    rs1_tag_i    = t1;
    rs2_rdy_i    = r2;
    rs2_tag_i    = t2;
    disp_valid_i = 1'b1;
  endtask

  task automatic bcast(input logic [4:0] tag, input logic [31:0] val);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = tag;
    cdb_val_i   = val;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_disp_ready", disp_ready_o, 0);
    check("rst_issue_valid", issue_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_issue_data", issue_data_o, 0);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", disp_ready_o, 1);

    // Single ready BNE issues the next cycle
    issue_ready_i = 1'b1;
    disp(32'h100, 1, 0, 32'd5, 1, 0, 32'd5, 0);
    #1;
    check("t1_empty_iv", issue_valid_o, 0);
    step();
    check("t1_iv", issue_valid_o, 1);
    check("t1_pc", issue_data_o.pc, 32'h100);
    check("t1_rs1", issue_data_o.rs1_val, 32'd5);
    check("t1_imm", issue_data_o.imm_val, 32'h10);
    check("t1_count", count_o, 1);
    step();
    check("t1_drain_count", count_o, 0);
    check("t1_drain_iv", issue_valid_o, 0);

    // rs1 waits on tag 3; wrong tag ignored; tag 3 wakes it one cycle later
    disp(32'h200, 0, 5'd3, 32'd0, 1, 0, 32'd9, 0);
    step();
    check("t2_wait_iv", issue_valid_o, 0);
    check("t2_count", count_o, 1);
    bcast(5'd4, 32'h55);
    #1;
    check("t2_wrongtag_iv", issue_valid_o, 0);
    step();
    check("t2_still_iv", issue_valid_o, 0);
    bcast(5'd3, 32'h44);
    #1;
    check("t2_bcast_cycle_iv", issue_valid_o, 0);
    step();
    check("t2_iv", issue_valid_o, 1);
    check("t2_rs1", issue_data_o.rs1_val, 32'h44);
    check("t2_rs2", issue_data_o.rs2_val, 32'd9);
    step();
    check("t2_count_end", count_o, 0);

    // A then B, held without handshake, then drained in order
    issue_ready_i = 1'b0;
    disp(32'h300, 1, 0, 32'd1, 1, 0, 32'd2, 0);
    step();
    disp(32'h304, 1, 0, 32'd3, 1, 0, 32'd4, 0);
    #1;
    check("t3_a_first", issue_data_o.pc, 32'h300);
    step();
    check("t3_count2", count_o, 2);
    step();
    check("t3_hold_count", count_o, 2);
    check("t3_hold_pc", issue_data_o.pc, 32'h300);
    issue_ready_i = 1'b1;
    step();
    check("t3_count1", count_o, 1);
    check("t3_b_pc", issue_data_o.pc, 32'h304);
    step();
    check("t3_count0", count_o, 0);
    check("t3_iv0", issue_valid_o, 0);

    // Fill to full, reject a 5th, wake all, drain in dispatch order
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(32'h400 + 32'(4 * i), 0, 5'd7, 32'd0, 1, 0, 32'd0, 0);
      #1;
      check("t4_fill_ready", disp_ready_o, 1);
      step();
    end
    disp(32'h410, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    #1;
    check("t4_full_ready", disp_ready_o, 0);
    check("t4_full_count", count_o, 4);
    step();
    check("t4_reject_count", count_o, 4);
    check("t4_none_ready", issue_valid_o, 0);
    bcast(5'd7, 32'h77);
    issue_ready_i = 1'b1;
    #1;
    check("t4_bcast_iv", issue_valid_o, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      check("t4_iv", issue_valid_o, 1);
      check("t4_pc", issue_data_o.pc, 32'h400 + 32'(4 * k));
      check("t4_rs1", issue_data_o.rs1_val, 32'h77);
      check("t4_disp_ready", disp_ready_o, (k == 0) ? 64'd0 : 64'd1);
      step();
    end
    check("t4_count_end", count_o, 0);

    // JALR ignores rs2 readiness; dispatch-cycle CDB bypass on rs1 and rs2
    disp(32'h600, 1, 0, 32'h1000, 0, 5'd9, 32'd0, 1);
    step();
    check("t5_jalr_iv", issue_valid_o, 1);
    check("t5_jalr_pc", issue_data_o.pc, 32'h600);
    check("t5_jalr_rs1", issue_data_o.rs1_val, 32'h1000);
    step();
    disp(32'h604, 0, 5'd12, 32'd0, 1, 0, 32'd3, 0);
    bcast(5'd12, 32'hABC);
    step();
    check("t5_byp1_iv", issue_valid_o, 1);
    check("t5_byp1_val", issue_data_o.rs1_val, 32'hABC);
    step();
    disp(32'h608, 1, 0, 32'd1, 0, 5'd13, 32'd0, 0);
    bcast(5'd13, 32'hDEF);
    step();
    check("t5_byp2_val", issue_data_o.rs2_val, 32'hDEF);
    step();
    check("t5_count_end", count_o, 0);

    // Simultaneous dispatch and issue keep count unchanged
    issue_ready_i = 1'b0;
    disp(32'h700, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    step();
    disp(32'h704, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    issue_ready_i = 1'b1;
    #1;
    check("t6_pc_a", issue_data_o.pc, 32'h700);
    step();
    check("t6_count", count_o, 1);
    check("t6_pc_b", issue_data_o.pc, 32'h704);
    step();
    check("t6_count_end", count_o, 0);

    // Age beats slot index: younger C reuses slot 0, older B in slot 1 goes first
    issue_ready_i = 1'b0;
    disp(32'h500, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    step();
    disp(32'h504, 0, 5'd6, 32'd0, 1, 0, 32'd0, 0);
    step();
    issue_ready_i = 1'b1;
    #1;
    check("t7_a_pc", issue_data_o.pc, 32'h500);
    step();
    issue_ready_i = 1'b0;
    disp(32'h508, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    bcast(5'd6, 32'h66);
    step();
    check("t7_count", count_o, 2);
    issue_ready_i = 1'b1;
    #1;
    check("t7_b_pc", issue_data_o.pc, 32'h504);
    check("t7_b_rs1", issue_data_o.rs1_val, 32'h66);
    step();
    check("t7_c_pc", issue_data_o.pc, 32'h508);
    step();
    check("t7_count_end", count_o, 0);

    // Flush clears held entries and ignores same-cycle inputs
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(32'h800 + 32'(4 * i), 0, 5'd2, 32'd0, 1, 0, 32'd0, 0);
      step();
    end
    check("t8_count3", count_o, 3);
    flush_i = 1'b1;
    disp(32'h80C, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    bcast(5'd2, 32'h22);
    issue_ready_i = 1'b1;
    #1;
    check("t8_flush_ready", disp_ready_o, 0);
    check("t8_flush_iv", issue_valid_o, 0);
    step();
    check("t8_count0", count_o, 0);
    check("t8_iv0", issue_valid_o, 0);
    step();
    check("t8_no_ghost", issue_valid_o, 0);

    // Mid-cycle reset discards held entries immediately
    issue_ready_i = 1'b0;
    disp(32'h900, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    step();
    disp(32'h904, 1, 0, 32'd0, 1, 0, 32'd0, 0);
    step();
    check("t9_count2", count_o, 2);
    check("t9_iv", issue_valid_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    check("t9_rst_count", count_o, 0);
    check("t9_rst_iv", issue_valid_o, 0);
    check("t9_rst_ready", disp_ready_o, 0);
    check("t9_rst_data", issue_data_o, 0);
    #1;
    reset_i = 1'b0;
    issue_ready_i = 1'b1;
    step();
    check("t9_after_iv", issue_valid_o, 0);
    check("t9_after_count", count_o, 0);
    check("t9_after_ready", disp_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
